// File: rtl/rgbw_sotp_gen.sv
`default_nettype none
// ============================================================================
// Module   : rgbw_sotp_gen
// Desc     : Pops pixel words from a read-latency-1 FIFO and drives them MSB
//            first as pulse-width-coded LED bits, with repeat and latch control.
// Revision : 1.0 - initial release
// ============================================================================
module rgbw_sotp_gen #(
    parameter int DATA_BITS    = 32,
    parameter int RGBW_T0H     = 24,
    parameter int RGBW_T0L     = 72,
    parameter int RGBW_T1H     = 48,
    parameter int RGBW_T1L     = 48,
    parameter int RGBW_STR_RST = 7680,
    parameter int COUNTER_MAX  = 7800
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_rd_fifo_empty,
    input  logic [DATA_BITS+7:0] in_rd_fifo_data,
    output logic                 out_rd_fifo_en,
    output logic                 out_sig,
    output logic                 out_busy,
    output logic                 out_latch_done
);
    localparam int CW = $clog2(COUNTER_MAX + 1);
    localparam int BW = $clog2(DATA_BITS);

    // Counters run from 0 to (duration - 1) in each timed state
    localparam logic [CW-1:0] c_t0h_last = CW'(RGBW_T0H - 1);
    localparam logic [CW-1:0] c_t0l_last = CW'(RGBW_T0L - 1);
    localparam logic [CW-1:0] c_t1h_last = CW'(RGBW_T1H - 1);
    localparam logic [CW-1:0] c_t1l_last = CW'(RGBW_T1L - 1);
    localparam logic [CW-1:0] c_str_last = CW'(RGBW_STR_RST - 1);
    localparam logic [BW-1:0] c_bit_last = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_next;
    logic [DATA_BITS-1:0] r_pixel;
    logic [DATA_BITS-1:0] r_shift;
    logic [5:0]           r_rep;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_latch_flag;
    logic                 r_sig;
    logic                 r_latch_done;
    logic                 w_cur_bit;
    logic [CW-1:0]        w_hi_last;
    logic [CW-1:0]        w_lo_last;
    logic                 w_low_end;
    logic                 w_last_bit;
    logic                 w_word_valid;
    logic                 w_word_latch;

    assign w_word_valid = in_rd_fifo_data[DATA_BITS+7];
    assign w_word_latch = in_rd_fifo_data[DATA_BITS+6];
    assign w_cur_bit    = r_shift[DATA_BITS-1];
    assign w_hi_last    = w_cur_bit ? c_t1h_last : c_t0h_last;
    assign w_lo_last    = w_cur_bit ? c_t1l_last : c_t0l_last;
    assign w_low_end    = (r_state == S_LOW) && (r_cnt == w_lo_last);
    assign w_last_bit   = (r_bit_idx == c_bit_last);

    assign out_rd_fifo_en = (r_state == S_IDLE) && !in_rd_fifo_empty && !rst;
    assign out_sig        = r_sig;
    assign out_busy       = (r_state != S_IDLE);
    assign out_latch_done = r_latch_done;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        case (r_state)
            S_IDLE: begin
                if (out_rd_fifo_en) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                if (w_word_valid)      w_state_next = S_HIGH;
                else if (w_word_latch) w_state_next = S_LATCH;
                else                   w_state_next = S_IDLE;
            end
            S_HIGH: begin
                if (r_cnt == w_hi_last) w_state_next = S_LOW;
                else                    w_cnt_next   = r_cnt + CW'(1);
            end
            S_LOW: begin
                if (w_low_end) begin
                    // Repeats reload straight into HIGH so copies stay contiguous
                    if (!w_last_bit || (r_rep != 6'd0)) w_state_next = S_HIGH;
                    else if (r_latch_flag)              w_state_next = S_LATCH;
                    else                                w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_LATCH: begin
                if (r_cnt == c_str_last) w_state_next = S_IDLE;
                else                     w_cnt_next   = r_cnt + CW'(1);
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_pixel      <= '0;
            r_shift      <= '0;
            r_rep        <= '0;
            r_bit_idx    <= '0;
            r_latch_flag <= 1'b0;
            r_sig        <= 1'b0;
            r_latch_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            // Registered outputs are derived from the next state to stay cycle-aligned
            r_sig        <= (w_state_next == S_HIGH);
            r_latch_done <= (w_state_next == S_LATCH) && (w_cnt_next == c_str_last);
            if (r_state == S_LOAD) begin
                r_pixel      <= in_rd_fifo_data[DATA_BITS-1:0];
                r_shift      <= in_rd_fifo_data[DATA_BITS-1:0];
                r_rep        <= in_rd_fifo_data[DATA_BITS+5:DATA_BITS];
                r_latch_flag <= w_word_latch;
                r_bit_idx    <= '0;
            end else if (w_low_end) begin
                if (!w_last_bit) begin
                    r_shift   <= {r_shift[DATA_BITS-2:0], 1'b0};
                    r_bit_idx <= r_bit_idx + BW'(1);
                end else if (r_rep != 6'd0) begin
                    r_rep     <= r_rep - 6'd1;
                    r_shift   <= r_pixel;
                    r_bit_idx <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/rgbw_sotp_gen.md
# rgbw_sotp_gen

Parametrised serial-output stage for SK6812-class addressable LED strings. It pops pixel words from a standard read-latency-1 FIFO and drives them MSB-first as pulse-width-coded bits on one line. Pixel width is configurable (RGB or RGBW), and the per-word control byte adds pixel repeat and on-demand string latch (reset) behaviour. It sits between the pixel FIFO and the output pin, as the drop-in successor to the fixed-width RGBW serializer.

## Interface
Parameters:
- DATA_BITS, 32: LED bits per pixel. Legal values are 24 and 32.
- RGBW_T0H, 24: clocks high for a 0 bit.
- RGBW_T0L, 72: clocks low for a 0 bit.
- RGBW_T1H, 48: clocks high for a 1 bit.
- RGBW_T1L, 48: clocks low for a 1 bit.
- RGBW_STR_RST, 7680: clocks low for a string latch.
- COUNTER_MAX, 7800: timing counter limit. Counter width is $clog2(COUNTER_MAX+1). All timing parameters must be ≥1 and ≤ COUNTER_MAX.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_rd_fifo_empty  in  1  FIFO empty flag.
- in_rd_fifo_data  in  DATA_BITS+8  FIFO word, valid the cycle after out_rd_fifo_en.
- out_rd_fifo_en  out  1  FIFO pop strobe.
- out_sig  out  1  serial LED line, registered.
- out_busy  out  1  high while a word is being processed.
- out_latch_done  out  1  one-cycle pulse at the end of a latch period.

## Operation
- Word format, with control byte C = data[DATA_BITS+7:DATA_BITS]:
  - C[7] = V (valid pixel).
  - C[6] = L (latch after).
  - C[5:0] = R (repeat count).
  - data[DATA_BITS-1:0] = pixel, sent MSB first.
- States: IDLE, LOAD, HIGH, LOW, LATCH.
- IDLE:
  - out_rd_fifo_en = (state==IDLE) && !in_rd_fifo_empty. This is combinational, and no other state asserts it.
  - When it is asserted, the next state is LOAD.
- LOAD: capture the word into the pixel register, the shift register, the repeat counter (=R) and the L flag.
  - V=1: go to HIGH for the MSB.
  - V=0 and L=1: go to LATCH. This is a latch-only command.
  - V=0 and L=0: discard the word and return to IDLE.
- HIGH: hold out_sig=1 for T0H or T1H clocks, selected by the current bit, then go to LOW.
- LOW: hold out_sig=0 for T0L or T1L clocks. Then:
  - If bits remain, shift and go to HIGH.
  - Else if the repeat counter is non-zero, decrement it, reload the shift register from the pixel register, and go to HIGH. There is no gap.
  - Else if L is set, go to LATCH.
  - Else go to IDLE.
- LATCH: hold out_sig=0 for RGBW_STR_RST clocks. Pulse out_latch_done on the final LATCH cycle, then go to IDLE.
- A pixel is transmitted R+1 times from a single FIFO read.
- out_busy = (state != IDLE).
- Reset mid-operation:
  - The next state is IDLE, and out_sig, out_busy and out_latch_done are all 0.
  - The pixel in progress is dropped. No automatic latch is issued.
  - out_rd_fifo_en is 0 in any cycle where rst=1.
- The FIFO-empty flag is ignored outside IDLE. An empty FIFO simply leaves the line low in IDLE.

## Timing
- Reset values: out_sig=0, out_busy=0, out_latch_done=0, out_rd_fifo_en=0. State is IDLE and all counters are 0.
- Pop at cycle P:
  - LOAD occurs at P+1.
  - For a valid pixel, the first out_sig high cycle is P+2.
- Bit cell length: T0H+T0L or T1H+T1L clocks exactly. Cells are contiguous within a pixel and across repeats.
- Pixel length is the sum of its cell lengths. One cell ends at cycle E, and the next high starts at E+1.
- Back-to-back FIFO words:
  - The last low cell of word N ends at E.
  - Pop occurs at E+1, LOAD at E+2, and the next high at E+3. This gives exactly 2 extra low clocks.
- Latch:
  - The line is low for T?L + RGBW_STR_RST clocks after the last high.
  - out_latch_done is high for one cycle, coincident with the last LATCH cycle.
  - The next pop can occur in the following cycle.
- Latch-only command: pop at P, LATCH cycles from P+2 to P+1+RGBW_STR_RST.
- Discarded word: out_busy is high for 1 cycle (LOAD) and out_sig stays 0.

## Test plan
Bench parameters: DATA_BITS=24, RGBW_T0H=2, RGBW_T0L=6, RGBW_T1H=4, RGBW_T1L=4, RGBW_STR_RST=20.
- Word 0x80112233 -> one pop strobe. 24 cells, 192 clocks total. High widths for the first byte are 2,2,2,4,2,2,2,4. No out_latch_done. out_busy falls after 193 cycles (LOAD plus cells).
- Word 0xC0112233 -> identical bit train, followed by 20 additional low clocks. A single out_latch_done pulse on the 20th of those clocks, then IDLE.
- Word 0x82AA55CC -> exactly one pop. The pixel is sent 3 times back-to-back: 576 clocks, no gap between repeats, second copy starts the cycle after the first copy's final low.
- Word 0x40000000 -> no high pulses. 20 low LATCH clocks and an out_latch_done pulse. Then word 0x00FFFFFF -> out_busy high for one cycle, out_sig stays 0.
- Two words queued with empty low -> second pop on E+1, second pixel's first high on E+3. Empty low throughout never causes a pop outside IDLE.
- rst asserted 50 cycles into the 0x80AA55CC transmission -> out_sig=0 and out_busy=0 on the next edge. No out_latch_done. No pop while rst is high. A subsequent word transmits normally.
